// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment display blocks: segment patterns,
// scan decoder state encoding, digit-slot indices and the BCD-to-binary step.
package sseg_pkg;

    // Segment patterns in gfedcba order, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_CONVERT = 2'd2
    } state_e;

    localparam int SLOT_ONES     = 0;
    localparam int SLOT_TENS     = 1;
    localparam int SLOT_HUNDREDS = 2;
    localparam int SLOT_UNUSED   = 3;
    localparam int NUM_SLOTS     = 3;

    localparam int BIN_W = 10;
    localparam int BCD_W = 12;
    localparam logic [3:0] CONVERT_STEPS = 4'd10;

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // One reverse double-dabble step over {bcd[11:0], bin[9:0]}.
    function automatic logic [BCD_W+BIN_W-1:0] dabble_step(input logic [BCD_W+BIN_W-1:0] r);
        logic [BCD_W+BIN_W-1:0] s;
        s = r >> 1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (s[BIN_W + 4*i +: 4] >= 4'd8) begin
                s[BIN_W + 4*i +: 4] = s[BIN_W + 4*i +: 4] - 4'd3;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/sseg_digit_decode.sv
// Combinational seven-segment pattern to BCD nibble decoder; blank reads as 0,
// anything outside the digit map reads as 0 with illegal raised.
module sseg_digit_decode
    import sseg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       illegal
);

    always_comb begin
        nibble  = 4'd0;
        illegal = 1'b0;
        case (pattern)
            SEG_0, SEG_BLANK: nibble = 4'd0;
            SEG_1:            nibble = 4'd1;
            SEG_2:            nibble = 4'd2;
            SEG_3:            nibble = 4'd3;
            SEG_4:            nibble = 4'd4;
            SEG_5:            nibble = 4'd5;
            SEG_6:            nibble = 4'd6;
            SEG_7:            nibble = 4'd7;
            SEG_8:            nibble = 4'd8;
            SEG_9:            nibble = 4'd9;
            default:          illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Scanned seven-segment receiver: debounces each digit slot, converts the captured
// BCD to a 9-bit address. Define SSEG_SCAN_DECODER_ACTIVE_LOW_EN for common-anode buses.
module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  sseg_indicator,
    input  logic [3:0]  digits,
    input  logic        ready,
    output logic [8:0]  address_out,
    output logic [11:0] bcd_out,
    output logic        valid,
    output logic        code_error,
    output logic        range_error
);

    localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

    logic [6:0] seg_in;
    logic [3:0] dig_in;
    logic       unused_dp;

`ifdef SSEG_SCAN_DECODER_ACTIVE_LOW_EN
    assign seg_in = ~sseg_indicator[6:0];
    assign dig_in = ~digits;
`else
    assign seg_in = sseg_indicator[6:0];
    assign dig_in = digits;
`endif
    assign unused_dp = sseg_indicator[7];

    logic [10:0] sample;
    logic        sample_one_hot;
    logic [3:0]  dec_nibble;
    logic        dec_illegal;

    assign sample         = {dig_in, seg_in};
    assign sample_one_hot = is_one_hot(dig_in);

    sseg_digit_decode u_digit_decode (
        .pattern (seg_in),
        .nibble  (dec_nibble),
        .illegal (dec_illegal)
    );

    state_e                    state_q, state_d;
    logic [10:0]               prev_q, prev_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [2:0]                flags_q, flags_d;
    logic [BCD_W-1:0]          slots_q, slots_d;
    logic                      frame_err_q, frame_err_d;
    logic [BCD_W+BIN_W-1:0]    conv_q, conv_d;
    logic [3:0]                conv_cnt_q, conv_cnt_d;
    logic                      conv_err_q, conv_err_d;
    logic [8:0]                address_q, address_d;
    logic [11:0]               bcd_out_q, bcd_out_d;
    logic                      valid_q, valid_d;
    logic                      code_error_q, code_error_d;
    logic                      range_error_q, range_error_d;
    logic                      latch_en;

    // A run latches only on the exact edge its count first reaches the limit.
    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        cnt_d         = cnt_q;
        flags_d       = flags_q;
        slots_d       = slots_q;
        frame_err_d   = frame_err_q;
        conv_d        = conv_q;
        conv_cnt_d    = conv_cnt_q;
        conv_err_d    = conv_err_q;
        address_d     = address_q;
        bcd_out_d     = bcd_out_q;
        valid_d       = valid_q;
        code_error_d  = code_error_q;
        range_error_d = range_error_q;
        latch_en      = 1'b0;

        case (state_q)
            ST_SCAN: begin
                prev_d = sample;
                if (!sample_one_hot) begin
                    cnt_d = 8'd0;
                end else if (sample == prev_q) begin
                    cnt_d = (cnt_q == STABLE_LIMIT) ? cnt_q : cnt_q + 8'd1;
                end else begin
                    cnt_d = 8'd1;
                end

                latch_en = sample_one_hot && !dig_in[SLOT_UNUSED]
                           && (cnt_d == STABLE_LIMIT) && (cnt_q != STABLE_LIMIT);

                if (latch_en) begin
                    if (dig_in[SLOT_ONES]) begin
                        slots_d[3:0]          = dec_nibble;
                        flags_d[SLOT_ONES]    = 1'b1;
                    end else if (dig_in[SLOT_TENS]) begin
                        slots_d[7:4]          = dec_nibble;
                        flags_d[SLOT_TENS]    = 1'b1;
                    end else begin
                        slots_d[11:8]         = dec_nibble;
                        flags_d[SLOT_HUNDREDS] = 1'b1;
                    end
                    if (dec_illegal) begin
                        frame_err_d = 1'b1;
                    end
                end

                if (&flags_d) begin
                    state_d     = ST_CONVERT;
                    conv_d      = {slots_d, {BIN_W{1'b0}}};
                    conv_cnt_d  = 4'd0;
                    conv_err_d  = frame_err_d;
                    flags_d     = 3'b000;
                    frame_err_d = 1'b0;
                    cnt_d       = 8'd0;
                    prev_d      = 11'd0;
                end
            end

            ST_CONVERT: begin
                if (conv_cnt_q < CONVERT_STEPS) begin
                    conv_d     = dabble_step(conv_q);
                    conv_cnt_d = conv_cnt_q + 4'd1;
                end else begin
                    state_d       = ST_PRESENT;
                    valid_d       = 1'b1;
                    bcd_out_d     = slots_q;
                    code_error_d  = conv_err_q;
                    range_error_d = conv_q[BIN_W-1];
                    address_d     = conv_q[BIN_W-1] ? 9'd0 : conv_q[8:0];
                end
            end

            ST_PRESENT: begin
                if (ready) begin
                    valid_d = 1'b0;
                    state_d = ST_SCAN;
                end
            end

            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_SCAN;
            prev_q        <= 11'd0;
            cnt_q         <= 8'd0;
            flags_q       <= 3'b000;
            slots_q       <= '0;
            frame_err_q   <= 1'b0;
            conv_q        <= '0;
            conv_cnt_q    <= 4'd0;
            conv_err_q    <= 1'b0;
            address_q     <= 9'd0;
            bcd_out_q     <= 12'd0;
            valid_q       <= 1'b0;
            code_error_q  <= 1'b0;
            range_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            flags_q       <= flags_d;
            slots_q       <= slots_d;
            frame_err_q   <= frame_err_d;
            conv_q        <= conv_d;
            conv_cnt_q    <= conv_cnt_d;
            conv_err_q    <= conv_err_d;
            address_q     <= address_d;
            bcd_out_q     <= bcd_out_d;
            valid_q       <= valid_d;
            code_error_q  <= code_error_d;
            range_error_q <= range_error_d;
        end
    end

    assign address_out = address_q;
    assign bcd_out     = bcd_out_q;
    assign valid       = valid_q;
    assign code_error  = code_error_q;
    assign range_error = range_error_q;

endmodule
